// File: rtl/lenet_layer_sched.sv
// -----------------------------------------------------------------------------
// lenet_layer_sched
//
// Frame-level sequencer for the LeNet layer pipeline. One start request walks
// the layer blocks (conv_1, pool_1, conv_2, pool_2, fc) in index order:
// a common reset phase, then for each layer an enable window that lasts until
// that layer reports finish, separated by idle gaps so every layer sees a
// fresh rising edge on its enable. A per-layer watchdog traps hung layers in
// an error state that only abort clears. Every output comes straight from a
// register.
//
// Ports
//   clk           single clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   start         one-cycle request to process one frame (IDLE only)
//   abort         one-cycle cancel of the frame / clear of an error
//   layer_finish  per-layer sticky finish levels
//   layer_en      per-layer enable, at most one bit high
//   layer_rst     synchronous reset to the layer blocks, all bits identical
//   busy          high whenever not IDLE
//   done          one-cycle pulse when the frame completes
//   error         high while in ERR
//   cur_layer     index of the active or next layer
//   frame_cycles  cycle count of the last completed frame
// -----------------------------------------------------------------------------
module lenet_layer_sched #(
    parameter int NUM_LAYERS = 5,
    parameter int CLR_CYCLES = 2,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_finish,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [NUM_LAYERS-1:0] layer_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            cur_layer,
    output logic [31:0]           frame_cycles
);

    localparam logic [31:0]           CLR_LAST   = 32'(CLR_CYCLES - 1);
    localparam logic [31:0]           GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]           WD_LAST    = 32'(TIMEOUT - 1);
    localparam logic [2:0]            LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] EN_ONE     = NUM_LAYERS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_reg, state_next;

    logic [31:0] phase_reg, phase_next;   // shared CLEAR / GAP cycle counter
    logic [31:0] wd_reg, wd_next;         // per-layer RUN watchdog
    logic [31:0] fc_reg, fc_next;         // running frame cycle counter
    logic [31:0] fc_inc;
    logic [31:0] frame_next;
    logic [2:0]  cur_next;
    logic        abort_taken;

    logic [NUM_LAYERS-1:0] layer_en_next;
    logic [NUM_LAYERS-1:0] layer_rst_next;
    logic                  busy_next;
    logic                  done_next;
    logic                  error_next;

    // Saturating increment so a pathological frame cannot wrap to a small value.
    assign fc_inc = (fc_reg == 32'hFFFF_FFFF) ? fc_reg : fc_reg + 32'd1;

    // -------------------------------------------------------------------------
    // State register (state, counters and all registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            phase_reg    <= '0;
            wd_reg       <= '0;
            fc_reg       <= '0;
            cur_layer    <= '0;
            frame_cycles <= '0;
            layer_en     <= '0;
            layer_rst    <= '1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            wd_reg       <= wd_next;
            fc_reg       <= fc_next;
            cur_layer    <= cur_next;
            frame_cycles <= frame_next;
            layer_en     <= layer_en_next;
            layer_rst    <= layer_rst_next;
            busy         <= busy_next;
            done         <= done_next;
            error        <= error_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        wd_next     = wd_reg;
        fc_next     = fc_reg;
        cur_next    = cur_layer;
        frame_next  = frame_cycles;
        abort_taken = 1'b0;

        if (state_reg == S_IDLE) begin
            // abort wins over a simultaneous start
            if (start && !abort) begin
                state_next = S_CLEAR;
                phase_next = '0;
                cur_next   = '0;
                fc_next    = '0;
            end
        end else if (abort) begin
            state_next  = S_IDLE;
            abort_taken = 1'b1;
        end else begin
            case (state_reg)
                S_CLEAR: begin
                    fc_next = fc_inc;
                    if (phase_reg == CLR_LAST) begin
                        state_next = S_RUN;
                        wd_next    = '0;
                    end else begin
                        phase_next = phase_reg + 32'd1;
                    end
                end
                S_RUN: begin
                    fc_next = fc_inc;
                    // Finish is checked before the watchdog so a finish on the
                    // last allowed cycle still advances.
                    if (layer_finish[cur_layer]) begin
                        if (cur_layer == LAST_LAYER) begin
                            state_next = S_DONE;
                            frame_next = fc_inc;
                        end else begin
                            state_next = S_GAP;
                            phase_next = '0;
                            cur_next   = cur_layer + 3'd1;
                        end
                    end else if (wd_reg == WD_LAST) begin
                        state_next = S_ERR;
                    end else begin
                        wd_next = wd_reg + 32'd1;
                    end
                end
                S_GAP: begin
                    fc_next = fc_inc;
                    if (phase_reg == GAP_LAST) begin
                        state_next = S_RUN;
                        wd_next    = '0;
                    end else begin
                        phase_next = phase_reg + 32'd1;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                S_ERR:   state_next = S_ERR;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: computed from the next state so outputs stay registered
    // -------------------------------------------------------------------------
    always_comb begin
        layer_en_next  = '0;
        layer_rst_next = '0;
        busy_next      = (state_next != S_IDLE);
        done_next      = (state_next == S_DONE);
        error_next     = (state_next == S_ERR);

        if (state_next == S_RUN) begin
            layer_en_next = EN_ONE << cur_next;
        end
        // Layers are held in reset through CLEAR and pulsed once on abort.
        if (state_next == S_CLEAR || abort_taken) begin
            layer_rst_next = '1;
        end
    end

endmodule

// File: tb/tb_lenet_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_lenet_layer_sched
//
// Self-checking bench for lenet_layer_sched (TIMEOUT reduced to 50). A small
// behavioural layer model raises finish a fixed number of cycles after its
// enable rises; a table of latencies drives back-to-back frames, and directed
// sequences cover timeout, stray finish, start/abort collisions and reset
// in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_lenet_layer_sched;

    localparam int NL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_finish;
    logic [NL-1:0] layer_en;
    logic [NL-1:0] layer_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    cur_layer;
    logic [31:0]   frame_cycles;

    int tests = 0;
    int fails = 0;

    // layer model state
    int            lat = 10;
    logic [NL-1:0] auto_mask = '1;
    logic [NL-1:0] manual_fin = '0;
    logic [NL-1:0] model_fin = '0;
    int            mcnt [NL];

    assign layer_finish = (model_fin & auto_mask) | manual_fin;

    lenet_layer_sched #(
        .NUM_LAYERS (NL),
        .CLR_CYCLES (2),
        .GAP_CYCLES (4),
        .TIMEOUT    (50)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .layer_finish (layer_finish),
        .layer_en     (layer_en),
        .layer_rst    (layer_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cur_layer    (cur_layer),
        .frame_cycles (frame_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    // Finish rises so that it is sampled in the cycle lat cycles after the
    // enable rose: the layer stays in RUN for lat+1 cycles.
    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (!rst_n || layer_rst[k]) begin
                mcnt[k]      = 0;
                model_fin[k] = 1'b0;
            end else if (layer_en[k]) begin
                mcnt[k] = mcnt[k] + 1;
                if (mcnt[k] > lat) model_fin[k] = 1'b1;
            end
        end
    end

    // one-hot enable and no enable while any layer is in reset
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            assert ($countones(layer_en) <= 1 && !(layer_rst != '0 && layer_en != '0))
            else begin
                fails++;
                $display("FAIL onehot: got en=%b rst=%b required popcount<=1 and en=0 under rst",
                         layer_en, layer_rst);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_en"},    layer_en, 0);
        check({tag, "_rst"},   layer_rst, 5'h1f);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_cur"},   cur_layer, 0);
        check({tag, "_frame"}, frame_cycles, 0);
    endtask

    // Called at a negedge; that cycle is cycle 0 (start high).
    // Returns at the negedge of the cycle after DONE.
    task automatic run_frame(input int l, input int exp_frame, input int exp_done, input string tag);
        int            cyc;
        int            done_cnt;
        int            done_cyc;
        int            err_seen;
        int            rise [NL];
        logic [NL-1:0] prev;
        lat       = l;
        auto_mask = '1;
        start     = 1'b1;
        cyc       = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        err_seen  = 0;
        prev      = '0;
        for (int k = 0; k < NL; k++) rise[k] = -1;
        while (!(done_cyc >= 0 && cyc >= done_cyc + 1) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            for (int k = 0; k < NL; k++)
                if (layer_en[k] && !prev[k] && rise[k] < 0) rise[k] = cyc;
            prev = layer_en;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (error) err_seen = 1;
        end
        for (int k = 0; k < NL; k++)
            check($sformatf("%s_en%0d_rise", tag, k), rise[k], 3 + k * (l + 1 + 4));
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_frame_cycles"}, frame_cycles, exp_frame);
        check({tag, "_no_error"}, err_seen, 0);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    typedef struct {
        int lat;
        int exp_frame;
        int exp_done;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc;
        int err_cyc;
        int rise2;

        // frame = CLR + 5*(lat+1) + 4*GAP ; done seen one cycle later
        vecs[0] = '{lat: 10, exp_frame: 73,  exp_done: 74};
        vecs[1] = '{lat: 0,  exp_frame: 23,  exp_done: 24};
        vecs[2] = '{lat: 5,  exp_frame: 48,  exp_done: 49};
        vecs[3] = '{lat: 49, exp_frame: 268, exp_done: 269};   // finish on last watchdog cycle

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_rst", layer_rst, 0);
        check("reset_release_busy", busy, 0);

        // ---------------- start + abort in IDLE ----------------
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_rst", layer_rst, 0);

        // ---------------- table-driven frames, back to back ----------------
        for (int i = 0; i < 4; i++)
            run_frame(vecs[i].lat, vecs[i].exp_frame, vecs[i].exp_done, $sformatf("vec%0d", i));

        // ---------------- timeout on layer 2 ----------------
        lat       = 10;
        auto_mask = 5'b11011;
        start     = 1'b1;
        cyc       = 0;
        err_cyc   = -1;
        rise2     = -1;
        while (err_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (layer_en[2] && rise2 < 0) rise2 = cyc;
            if (error) err_cyc = cyc;
        end
        check("tmo_en2_rise", rise2, 33);
        check("tmo_error_cycle", err_cyc, 83);
        check("tmo_cur_layer", cur_layer, 2);
        check("tmo_en_low", layer_en, 0);
        repeat (5) @(negedge clk);
        check("tmo_error_held", error, 1);
        check("tmo_busy_held", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("tmo_abort_busy", busy, 0);
        check("tmo_abort_error", error, 0);
        check("tmo_abort_rst_pulse", layer_rst, 5'h1f);
        check("tmo_abort_frame_kept", frame_cycles, 268);
        @(negedge clk);
        check("tmo_abort_rst_end", layer_rst, 0);

        // ---------------- stray finish and start during RUN ----------------
        auto_mask = 5'b00001;
        start     = 1'b1;
        cyc       = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        check("stray_pre_en", layer_en, 5'b00010);
        manual_fin = 5'b10000;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("stray_en_held", layer_en, 5'b00010);
        check("stray_cur_held", cur_layer, 1);
        check("stray_no_error", error, 0);
        manual_fin = '0;
        abort      = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("stray_abort_busy", busy, 0);
        @(negedge clk);

        // ---------------- reset in the middle of layer 3 ----------------
        auto_mask = '1;
        lat       = 10;
        start     = 1'b1;
        cyc       = 0;
        while (cyc < 55) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        check("midrst_pre_cur", cur_layer, 3);
        check("midrst_pre_en", layer_en, 5'b01000);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_rst", layer_rst, 0);
        run_frame(10, 73, 74, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lenet_layer_sched.md
LENET_LAYER_SCHED -- requirements
Module: lenet_layer_sched

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 5, number of layers sequenced: conv_1, pool_1, conv_2, pool_2, fc, in index order 0..4.
REQ-002 SHALL have parameter CLR_CYCLES, default 2, cycles layer_rst is held before layer 0 starts.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle cycles between consecutive layers, with all layer_en low.
REQ-004 SHALL have parameter TIMEOUT, default 1000000, maximum RUN cycles per layer before error.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, one-cycle request to process one frame.
REQ-008 SHALL have port abort, input, 1 bit, one-cycle request to cancel the frame or clear an error.
REQ-009 SHALL have port layer_finish, input, NUM_LAYERS bits, per-layer finish level; sticky until that layer is reset.
REQ-010 SHALL have port layer_en, output, NUM_LAYERS bits, per-layer enable level, at most one bit high.
REQ-011 SHALL have port layer_rst, output, NUM_LAYERS bits, synchronous active-high reset to layer blocks, all bits identical.
REQ-012 SHALL have port busy, output, 1 bit, high in any state except IDLE.
REQ-013 SHALL have port done, output, 1 bit, one-cycle pulse when the frame is complete.
REQ-014 SHALL have port error, output, 1 bit, high only in ERR.
REQ-015 SHALL have port cur_layer, output, 3 bits, index of the active or next layer.
REQ-016 SHALL have port frame_cycles, output, 32 bits, cycle count of the last completed frame.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, RUN, GAP, DONE, ERR, and drive every output from a register.
REQ-018 SHALL, in IDLE, on start=1 and abort=0: go to CLEAR, set cur_layer=0, and clear the frame counter.
REQ-019 SHALL ignore start outside IDLE, and SHALL give abort priority when start and abort arrive in the same cycle.
REQ-020 SHALL, in CLEAR, hold layer_rst all-ones for exactly CLR_CYCLES cycles with layer_en=0, then go to RUN.
REQ-021 SHALL, in RUN, set layer_en[cur_layer]=1 and all other bits 0; first layer_en[0] high exactly CLR_CYCLES+1 cycles after the start cycle.
REQ-022 SHALL, in RUN, treat only layer_finish[cur_layer] as valid; finish bits of other layers are ignored.
REQ-023 SHALL, in RUN, on layer_finish[cur_layer]=1, drop layer_en to 0 next cycle, then go to DONE if cur_layer==NUM_LAYERS-1, else go to GAP with cur_layer+1.
REQ-024 SHALL, in GAP, hold layer_en=0 for exactly GAP_CYCLES cycles, then go to RUN; this guarantees each layer sees a rising edge of its enable.
REQ-025 SHALL reload the per-layer watchdog to 0 on each RUN entry and increment it every RUN cycle.
REQ-026 SHALL go to ERR with layer_en=0 when the watchdog reaches TIMEOUT-1 with no finish; if finish and timeout occur in the same cycle, finish wins.
REQ-027 SHALL, in ERR, keep error=1 and cur_layer frozen at the failing layer, leaving ERR only on abort.
REQ-028 SHALL, on abort in any non-IDLE state: go to IDLE next cycle, set layer_en=0, pulse layer_rst for 1 cycle, and clear error; frame_cycles is not updated.
REQ-029 SHALL increment the frame counter every cycle from CLEAR entry until DONE entry, saturating at 2^32-1.
REQ-030 SHALL, in DONE, latch the frame counter into frame_cycles, pulse done for 1 cycle, then go to IDLE; start is accepted again in the cycle after DONE.

Reset
REQ-031 SHALL, on rst_n=0 and asynchronously: set state=IDLE, layer_en=0, layer_rst=all-ones, busy=0, done=0, error=0, cur_layer=0, frame_cycles=0, and clear watchdog and counters.
REQ-032 SHALL deassert layer_rst on the first clock after rst_n rises, with reset mid-frame behaving identically.

Verification
REQ-033 SHALL verify nominal frame: start at cycle 0, each layer finishes 10 cycles after its enable rises -> layer_en[0] at cycle 3, layer_en advances 0..4 with 4-cycle gaps, done pulses once, frame_cycles = constant matching model.
REQ-034 SHALL verify timeout: TIMEOUT=50, layer 2 never finishes -> error=1 after 50 RUN cycles, cur_layer=2, layer_en=0; then abort -> IDLE, error=0, one-cycle layer_rst.
REQ-035 SHALL verify stray finish: layer_finish[4]=1 while cur_layer=1 -> no advance; start during RUN -> ignored.
REQ-036 SHALL verify simultaneous events: start+abort in IDLE -> stays IDLE; finish on the TIMEOUT-1 cycle -> advances, no error.
REQ-037 SHALL verify reset mid-frame: rst_n low during RUN of layer 3 -> all outputs at reset values immediately; next start runs a full frame from layer 0.
REQ-038 SHALL verify one-hot property: assertion that popcount(layer_en)<=1 every cycle and that layer_en=0 whenever layer_rst!=0.
